// File: rtl/param_regfile_pkg.sv
// rtl/param_regfile_pkg.sv - shared types, default parameters and helpers for param_regfile
package param_regfile_pkg;

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} rf_state_e;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_DEPTH    = 32;
  localparam int DEF_NUM_RD   = 2;
  localparam int DEF_ZERO_REG = 1;

  // True when addr names a real entry; only matters for non-power-of-two depths.
  function automatic logic rf_addr_ok(input logic [31:0] addr, input logic [31:0] depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/param_regfile_if.sv
// rtl/param_regfile_if.sv - write, clear-request and read-port bus of param_regfile
interface param_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) ();

  logic                     clr_req;
  logic                     we;
  logic [ADDR_W-1:0]        waddr;
  logic [DATA_W-1:0]        wdata;
  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic                     busy;
  logic                     wr_drop;

  modport master (
    output clr_req, we, waddr, wdata, raddr,
    input  rdata, busy, wr_drop
  );

  modport slave (
    input  clr_req, we, waddr, wdata, raddr,
    output rdata, busy, wr_drop
  );

endinterface

// File: rtl/param_regfile_clr_seq.sv
// rtl/param_regfile_clr_seq.sv - clear sequencer: zeroes one entry per cycle after reset or on request
module param_regfile_clr_seq
  import param_regfile_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  rf_state_e         state, state_next;
  logic [ADDR_W-1:0] clr_idx, clr_idx_next;

  // State and index registers; reset always restarts a full clear from entry 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_next;
      clr_idx <= clr_idx_next;
    end
  end

  // Walk the index through every entry, then idle until a clear is requested.
  always_comb begin
    state_next   = state;
    clr_idx_next = clr_idx;
    case (state)
      CLEAR: begin
        if (clr_idx == LAST_IDX) begin
          state_next   = READY;
          clr_idx_next = '0;
        end else begin
          clr_idx_next = clr_idx + ADDR_W'(1);
        end
      end
      READY: begin
        if (clr_req) begin
          state_next   = CLEAR;
          clr_idx_next = '0;
        end
      end
      default: state_next = CLEAR;
    endcase
  end

  assign busy     = (state == CLEAR);
  assign clr_we   = busy;
  assign clr_addr = clr_idx;

endmodule

// File: rtl/param_regfile.sv
// rtl/param_regfile.sv - multi-read-port register file with clear engine; PARAM_REGFILE_BYPASS_EN enables write-to-read forwarding
module param_regfile
  import param_regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = DEF_ZERO_REG
) (
  input logic           clk,
  input logic           rst,
  param_regfile_if.slave bus
);

  logic                     busy;
  logic                     clr_we;
  logic [ADDR_W-1:0]        clr_addr;
  logic                     wr_legal;
  logic                     wr_commit;
  logic                     wr_drop;
  logic [NUM_RD*DATA_W-1:0] rdata_all;
  logic [DATA_W-1:0]        mem [DEPTH];

  param_regfile_clr_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clr_seq (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (bus.clr_req),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign wr_legal  = rf_addr_ok(32'(bus.waddr), 32'(DEPTH))
                   && !((ZERO_REG != 0) && (bus.waddr == '0));
  assign wr_commit = bus.we && !busy && wr_legal && !rst;

  // Storage: the clear engine owns the write port while busy; reset suppresses both writers.
  always_ff @(posedge clk) begin
    if (!rst && clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_commit) begin
      mem[bus.waddr] <= bus.wdata;
    end
  end

  // Flag any requested write that did not reach the array.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_drop <= 1'b0;
    end else begin
      wr_drop <= bus.we && !(wr_legal && !busy);
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;

    assign ra = bus.raddr[k*ADDR_W +: ADDR_W];

    // Read port: busy / zero-entry / out-of-range force 0, then optional forwarding, then the array.
    always_comb begin
      rd = '0;
      if (!(busy || !rf_addr_ok(32'(ra), 32'(DEPTH)) || ((ZERO_REG != 0) && (ra == '0)))) begin
`ifdef PARAM_REGFILE_BYPASS_EN
        if (wr_commit && (ra == bus.waddr)) begin
          rd = bus.wdata;
        end else begin
          rd = mem[ra];
        end
`else
        rd = mem[ra];
`endif
      end
    end

    assign rdata_all[k*DATA_W +: DATA_W] = rd;
  end

  assign bus.rdata   = rdata_all;
  assign bus.busy    = busy;
  assign bus.wr_drop = wr_drop;

endmodule
